// File: rtl/camera_pkg.sv
// camera_pkg: BT.656 preamble constants, code-search FSM states and XY bit positions.
// CAM_BT656_PROT_EN widens the XY view to include the protection bits.
package camera_pkg;
  localparam logic [7:0] PRE_FF = 8'hFF;
  localparam logic [7:0] PRE_00 = 8'h00;
  localparam int XY_ONE = 7;
  localparam int XY_F = 6;
  localparam int XY_V = 5;
  localparam int XY_H = 4;
`ifdef CAM_BT656_PROT_EN
  localparam int XY_P3 = 3;
  localparam int XY_P2 = 2;
  localparam int XY_P1 = 1;
  localparam int XY_P0 = 0;
  localparam int XY_LSB = 0;
`else
  localparam int XY_LSB = 4;
`endif
  typedef enum logic [1:0] {SEARCH, P1, P2, P3} fsm_e;
endpackage

// File: rtl/camera_bt656_xy_check.sv
// camera_bt656_xy_check: decodes F/V/H from an XY word and flags it valid;
// parity of P3..P0 is also checked when CAM_BT656_PROT_EN is defined.
module camera_bt656_xy_check import camera_pkg::*; (
  input  logic [7:XY_LSB] xy,
  output logic            f,
  output logic            v,
  output logic            h,
  output logic            valid
);
  assign f = xy[XY_F];
  assign v = xy[XY_V];
  assign h = xy[XY_H];
`ifdef CAM_BT656_PROT_EN
  assign valid = xy[XY_ONE] && xy[XY_P3] == (v ^ h) && xy[XY_P2] == (f ^ h) &&
                 xy[XY_P1] == (f ^ v) && xy[XY_P0] == (f ^ v ^ h);
`else
  assign valid = xy[XY_ONE];
`endif
endmodule

// File: rtl/camera_bt656_decoder.sv
// camera_bt656_decoder: BT.656 embedded-sync to discrete hsync/vsync strobes with a 4-deep data pipe.
// Optional XY protection check: define CAM_BT656_PROT_EN.
module camera_bt656_decoder import camera_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                  s_cam_clk_dft,
  input  logic                  rstn_i,
  input  logic                  cfg_en_i,
  input  logic [DATA_WIDTH-1:0] cam_data_i,
  output logic [DATA_WIDTH-1:0] cam_data_o,
  output logic                  cam_hsync_o,
  output logic                  cam_vsync_o,
  output logic                  field_o,
  output logic                  sync_lock_o,
  output logic [ERR_CNT_W-1:0]  err_cnt_o
);
  typedef struct packed {
    logic [DATA_WIDTH-1:0] d;
    logic                  act;
    logic                  vs;
    logic                  f;
  } pipe_t;
  logic en_q, en_s;
  fsm_e state, state_nx;
  logic [7:0] code;
  logic xy_f, xy_v, xy_h, xy_ok, acc, rej;
  logic line_active, v_q, f_q, lock;
  logic [ERR_CNT_W-1:0] err_cnt;
  pipe_t p [4];
  assign code = cam_data_i[DATA_WIDTH-1 -: 8];
  camera_bt656_xy_check u_xy (
    .xy    (code[7:XY_LSB]),
    .f     (xy_f),
    .v     (xy_v),
    .h     (xy_h),
    .valid (xy_ok)
  );
  always_ff @(posedge s_cam_clk_dft or negedge rstn_i)
    if (!rstn_i) begin
      en_q  <= 1'b0;
      en_s  <= 1'b0;
      state <= SEARCH;
    end else begin
      en_q  <= cfg_en_i;
      en_s  <= en_q;
      state <= state_nx;
    end
  // An FF anywhere before XY restarts the preamble; XY itself always returns to SEARCH.
  always_comb begin
    state_nx = (!en_s || state == P3) ? SEARCH :
               code == PRE_FF ? P1 :
               (state == P1 && code == PRE_00) ? P2 :
               (state == P2 && code == PRE_00) ? P3 : SEARCH;
    acc = en_s && state == P3 && xy_ok;
    rej = en_s && state == P3 && !xy_ok;
  end
  always_ff @(posedge s_cam_clk_dft or negedge rstn_i)
    if (!rstn_i) begin
      line_active <= 1'b0;
      v_q         <= 1'b0;
      f_q         <= 1'b0;
      lock        <= 1'b0;
      err_cnt     <= '0;
    end else if (!en_s) begin
      line_active <= 1'b0;
      v_q         <= 1'b0;
      f_q         <= 1'b0;
      lock        <= 1'b0;
      err_cnt     <= '0;
    end else begin
      if (acc) begin
        line_active <= !xy_h && !xy_v;
        v_q         <= xy_v;
        f_q         <= xy_f;
      end
      if (acc) lock <= 1'b1;
      else if (rej) lock <= 1'b0;
      if (rej && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
    end
  // On an accepted code the preamble words still in flight lose their active flag.
  always_ff @(posedge s_cam_clk_dft or negedge rstn_i)
    if (!rstn_i) begin
      for (int i = 0; i < 4; i++) p[i] <= '0;
    end else begin
      p[0] <= '{d: cam_data_i, act: en_s && !acc && line_active,
                vs: acc ? xy_v : v_q, f: acc ? xy_f : f_q};
      for (int i = 1; i < 4; i++) begin
        p[i]     <= p[i-1];
        p[i].act <= p[i-1].act && !acc;
      end
    end
  assign cam_data_o  = p[3].d;
  assign cam_hsync_o = p[3].act;
  assign cam_vsync_o = p[3].vs;
  assign field_o     = p[3].f;
  assign sync_lock_o = lock;
  assign err_cnt_o   = err_cnt;
endmodule

// File: doc/camera_bt656_decoder.md
# camera_bt656_decoder

Front-end stage in the camera clock domain that turns an ITU-R BT.656 stream into discrete line and frame strobes, so sensors with embedded sync can drive the existing camera interface pixel path. It searches for FF 00 00 XY timing reference codes, decodes F/V/H, strips code words from the active window, and delays data to match. Outputs feed cam_data_i, cam_hsync_i and cam_vsync_i of the camera interface, vsync polarity set to active-high.

## Interface
- DATA_WIDTH, 8: pixel bus width; codes compared on bits [DATA_WIDTH-1 -: 8].
- ERR_CNT_W, 8: width of saturating error counter.
- s_cam_clk_dft  in  1  camera pixel clock (DFT-muxed); all logic on posedge.
- rstn_i  in  1  asynchronous, active-low reset.
- cfg_en_i  in  1  decoder enable from clk_i domain, quasi-static; 2-flop synchronized internally.
- cam_data_i  in  DATA_WIDTH  raw BT.656 stream.
- cam_data_o  out  DATA_WIDTH  stream delayed 4 cycles.
- cam_hsync_o  out  1  high only on active-video samples.
- cam_vsync_o  out  1  V flag of last accepted code (1 = vertical blanking).
- field_o  out  1  F flag of last accepted code.
- sync_lock_o  out  1  valid code seen since enable / last error.
- err_cnt_o  out  ERR_CNT_W  rejected-code count, saturating.

## Operation
- Code FSM: SEARCH -> P1 on FF; P1 -> P2 on 00, else SEARCH (P1 if FF); P2 -> P3 on 00, else SEARCH/P1 as above; P3 -> SEARCH always, XY checked this cycle.
- XY accepted when bit7=1 (and protection passes if compiled in). Rejected XY: flags unchanged, err_cnt +1 (saturate at all-ones), sync_lock cleared.
- Accepted XY: F->field reg, V->vsync reg, sync_lock set; H=0 with V=0 (SAV) sets line_active; H=1 (EAV) or V=1 clears line_active.
- Pipe: 4 entries {data, act, vs, f}; p0 <= {cam_data_i, line_active, V reg, F reg} each cycle; p1..p3 shift. Outputs are p3 fields.
- On accepted XY at cycle t: new p0 gets act=0 and new V/F; p1..p3 (carrying 00,00,FF) get act=0 when shifted. Code words never appear with cam_hsync_o=1.
- Disabled (synced enable low): FSM SEARCH, line_active=0, V/F regs=0, sync_lock=0, err_cnt=0, new p0 act=0; pipe keeps shifting so data drains.
- Enable rising: decoding starts from SEARCH; no act until first SAV.

## Timing
- Reset: cam_data_o=0, cam_hsync_o=0, cam_vsync_o=0, field_o=0, sync_lock_o=0, err_cnt_o=0; FSM SEARCH; pipe cleared.
- Latency: word at input edge t on cam_data_o after edge t+4; hsync/vsync/field aligned to same word.
- SAV XY at input t: first active sample (t+1) emerges with cam_hsync_o=1 at t+5; last active sample before EAV FF is final hsync-high output.
- sync_lock_o, err_cnt_o update at edge after XY (not pipelined).
- Enable sync: 2 cycles from cfg_en_i change to effect.
- FF FF 00 00 XY: second FF restarts preamble, code still detected.
- Mid-line reset: everything async to reset values; no residual hsync.

## Configuration
- CAM_BT656_PROT_EN defined: XY also checked with P3=V^H, P2=F^H, P1=F^V, P0=F^V^H; any mismatch rejects code (counted error). No correction.
- Undefined: P3..P0 ignored, only bit7 checked; checker logic absent.

## Structure
- camera_pkg: preamble constants (8'hFF, 8'h00), FSM enum (SEARCH, P1, P2, P3), XY bit positions.
- Sub-module camera_bt656_xy_check: combinational XY decode -> F, V, H, valid; protection check inside under CAM_BT656_PROT_EN.

## Test plan
- Line FF 00 00 80, 4 samples 10 11 12 13, FF 00 00 9D -> hsync_o high exactly on 10..13 (4 cycles, starting 5 cycles after 80); no code word with hsync_o high.
- Code FF 00 00 B6 (V=1, EAV) -> cam_vsync_o 0->1 aligned with B6 on output; later SAV with V=0 -> vsync_o 1->0.
- With CAM_BT656_PROT_EN, XY 81 (bad parity) -> rejected, err_cnt_o=1, sync_lock_o=0, hsync stays low; without macro -> accepted as SAV.
- XY 00 (bit7=0) 300 times -> err_cnt_o saturates at 255.
- Stream FF FF 00 00 80 -> detected as SAV; FF 00 01 80 -> not detected.
- Drop cfg_en_i mid-line -> 2 cycles later new entries act=0, hsync_o low 4 cycles after; sync_lock_o=0, err_cnt_o=0; async reset mid-line -> all outputs 0 at once.
